// File: rtl/filter_seq_ctrl_if.sv
// Strobe/handshake bundle between filter_seq_ctrl (master) and the filter datapath plus downstream consumer (slave).
interface filter_seq_ctrl_if #(
  parameter int AW = 6
);
  logic          sampleEn;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [AW-1:0] rdAddr;
  logic          accClr;
  logic          accEn;
  logic          outLoad;
  logic          outVld;
  logic          outRdy;

  modport master (
    output sampleEn, wrEn, wrAddr, rdAddr, accClr, accEn, outLoad, outVld,
    input  outRdy
  );

  modport slave (
    input  sampleEn, wrEn, wrAddr, rdAddr, accClr, accEn, outLoad, outVld,
    output outRdy
  );
endinterface

// File: rtl/filter_seq_ctrl.sv
// Sequencer for the second-difference filter and window averager: decimation strobe, write pointer, read sweep, output handshake.
// Optional build macro FILL_SKIP_EN: request a sweep on every write, even before the window has been filled once.
module filter_seq_ctrl #(
  parameter int DECIM    = 64,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int FILT_LAT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  filter_seq_ctrl_if.master  bus,
  output logic               o_full,
  output logic               o_overrun
);

  typedef enum logic [2:0] {IDLE, CLR, ACC, LOAD, HOLD} state_t;

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic [FILT_LAT-1:0] r_filPipe;
  logic [AW-1:0]       r_wrAddr;
  logic [AW-1:0]       r_rdAddr;
  logic                r_full;
  logic                r_overrun;
  logic                r_accClr;
  logic                r_accEn;
  logic                r_outLoad;
  logic                r_outVld;

  logic                w_sampleEn;
  logic                w_wrEn;
  logic                w_lastWrite;
  logic                w_req;
  logic                w_busy;

  assign w_sampleEn  = i_en && (r_cnt == 16'(DECIM - 1));
  assign w_wrEn      = r_filPipe[FILT_LAT-1];
  assign w_lastWrite = (r_wrAddr == AW'(DEPTH - 1));

`ifdef FILL_SKIP_EN
  assign w_req = w_wrEn;
`else
  assign w_req = w_wrEn && (r_full || w_lastWrite);
`endif

  // A request arriving while a sweep is running, or while a result is still unaccepted, is dropped.
  assign w_busy = (r_state == CLR) || (r_state == ACC) || (r_state == LOAD) ||
                  ((r_state == HOLD) && !bus.outRdy);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_filPipe <= '0;
      r_wrAddr  <= '0;
      r_full    <= 1'b0;
    end else begin
      if (i_en) begin
        r_cnt <= w_sampleEn ? 16'd0 : r_cnt + 16'd1;
      end
      r_filPipe <= (r_filPipe << 1) | FILT_LAT'(w_sampleEn);
      if (w_wrEn) begin
        r_wrAddr <= r_wrAddr + AW'(1);
        if (w_lastWrite) begin
          r_full <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_rdAddr  <= '0;
      r_accClr  <= 1'b0;
      r_accEn   <= 1'b0;
      r_outLoad <= 1'b0;
      r_outVld  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_accClr  <= 1'b0;
      r_outLoad <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state  <= CLR;
            r_accClr <= 1'b1;
          end
        end
        CLR: begin
          r_state  <= ACC;
          r_accEn  <= 1'b1;
          r_rdAddr <= '0;
        end
        ACC: begin
          if (r_rdAddr == AW'(DEPTH - 1)) begin
            r_state   <= LOAD;
            r_accEn   <= 1'b0;
            r_outLoad <= 1'b1;
          end else begin
            r_rdAddr <= r_rdAddr + AW'(1);
          end
        end
        LOAD: begin
          r_state  <= HOLD;
          r_outVld <= 1'b1;
        end
        HOLD: begin
          // Acceptance and a new request in the same cycle chain straight into the next sweep.
          if (bus.outRdy) begin
            r_outVld <= 1'b0;
            if (w_req) begin
              r_state  <= CLR;
              r_accClr <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_req && w_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.sampleEn = w_sampleEn;
  assign bus.wrEn     = w_wrEn;
  assign bus.wrAddr   = r_wrAddr;
  assign bus.rdAddr   = r_rdAddr;
  assign bus.accClr   = r_accClr;
  assign bus.accEn    = r_accEn;
  assign bus.outLoad  = r_outLoad;
  assign bus.outVld   = r_outVld;
  assign o_full       = r_full;
  assign o_overrun    = r_overrun;

endmodule
